// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction width, bubble encoding, PC step and
// the fetch FSM state encoding used by fetch_stage and its bench.
package cpu_pkg;

    localparam int              INSTR_W   = 32;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam int              PC_INC    = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: while imem_req_o=1 the memory returns imem_rdata_i for imem_addr_o in the
// same cycle and marks it with imem_rvalid_i=1; the address stays put until rvalid=1 or a redirect.
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int PC_W = 64
);
    logic               imem_req_o;
    logic [PC_W-1:0]    imem_addr_o;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               imem_rvalid_i;

    modport master (output imem_req_o, output imem_addr_o,
                    input  imem_rdata_i, input imem_rvalid_i);
    modport slave  (input  imem_req_o, input imem_addr_o,
                    output imem_rdata_i, output imem_rvalid_i);
endinterface

// File: rtl/fetch_perf_counters.sv
// Two saturating event counters for the fetch stage (delivered words, inserted bubbles).
module fetch_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_fetch_i,
    input  logic             inc_bubble_i,
    output logic [CNT_W-1:0] cnt_fetch_o,
    output logic [CNT_W-1:0] cnt_bubble_o
);
    logic [CNT_W-1:0] cnt_fetch_q, cnt_fetch_d;
    logic [CNT_W-1:0] cnt_bubble_q, cnt_bubble_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt_fetch_d  = cnt_fetch_q;
        cnt_bubble_d = cnt_bubble_q;
        if (inc_fetch_i && !(&cnt_fetch_q))
            cnt_fetch_d = cnt_fetch_q + 1'b1;
        if (inc_bubble_i && !(&cnt_bubble_q))
            cnt_bubble_d = cnt_bubble_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_fetch_q  <= '0;
            cnt_bubble_q <= '0;
        end else begin
            cnt_fetch_q  <= cnt_fetch_d;
            cnt_bubble_q <= cnt_bubble_d;
        end
    end

    assign cnt_fetch_o  = cnt_fetch_q;
    assign cnt_bubble_o = cnt_bubble_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: PC, imem request, stall/flush/redirect.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                 PC_W      = 64,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter int                 CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                branch_taken_i,
    input  logic [PC_W-1:0]     branch_target_i,
    input  logic                jump_i,
    input  logic [PC_W-1:0]     jump_target_i,
    fetch_stage_if.master       imem,
    output logic [PC_W-1:0]     if_id_pc_o,
    output logic [INSTR_W-1:0]  if_id_instr_o,
    output logic                if_id_valid_o,
    output logic [CNT_W-1:0]    cnt_fetch_o,
    output logic [CNT_W-1:0]    cnt_bubble_o,
    output fetch_state_e        state_o
);
    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;

    logic               active;
    logic               redirect;
    logic               advance;
    logic               load_valid;
    logic               load_bubble;
    logic [PC_W-1:0]    redirect_pc;

    // Priority: jump > branch > flush > stall > fetch. A redirect overrides stall.
    always_comb begin
        active      = (state_q == ST_RUN) || (state_q == ST_WAIT);
        redirect    = active && (jump_i || branch_taken_i);
        redirect_pc = jump_i ? jump_target_i : branch_target_i;
        advance     = active && !redirect && (flush_i || !stall_i) && imem.imem_rvalid_i;
        load_valid  = active && !redirect && !flush_i && !stall_i && imem.imem_rvalid_i;
        load_bubble = redirect ||
                      (active && (flush_i || (!stall_i && !imem.imem_rvalid_i)));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_WAIT: begin
                if (redirect)
                    state_d = ST_RUN;
                else if (flush_i || !stall_i)
                    state_d = imem.imem_rvalid_i ? ST_RUN : ST_WAIT;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        imem.imem_req_o  = active;
        imem.imem_addr_o = pc_q;
        state_o          = state_q;
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect)
            pc_d = redirect_pc;
        else if (advance)
            pc_d = pc_q + PC_W'(PC_INC);
        if (load_bubble) begin
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (load_valid) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem.imem_rdata_i;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst          (rst),
        .inc_fetch_i  (load_valid),
        .inc_bubble_i (load_bubble),
        .cnt_fetch_o  (cnt_fetch_o),
        .cnt_bubble_o (cnt_bubble_o)
    );
`else
    assign cnt_fetch_o  = '0;
    assign cnt_bubble_o = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a
// behavioural model of the fetch rules.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int          PC_W     = 64;
    localparam int          CNT_W    = 32;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, stall_i, flush_i, branch_taken_i, jump_i;
    logic [PC_W-1:0]  branch_target_i, jump_target_i;
    logic [PC_W-1:0]  if_id_pc_o;
    logic [31:0]      if_id_instr_o;
    logic             if_id_valid_o;
    logic [CNT_W-1:0] cnt_fetch_o, cnt_bubble_o;
    fetch_state_e     state_o;

    fetch_stage_if #(.PC_W(PC_W)) imem_bus ();

    fetch_stage #(.PC_W(PC_W), .RESET_PC(RESET_PC), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem            (imem_bus),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .cnt_fetch_o     (cnt_fetch_o),
        .cnt_bubble_o    (cnt_bubble_o),
        .state_o         (state_o)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [63:0]      m_pc, m_if_pc;
    logic [31:0]      m_if_instr;
    logic             m_if_valid, m_boot, m_wait;
    logic [CNT_W-1:0] m_nf, m_nb;
    logic [95:0]      exp_q[$];

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        return {pc[24:0], 7'h13} ^ 32'h5A00_0000;
    endfunction

    function automatic fetch_state_e m_state();
        if (m_boot) return ST_BOOT;
        return m_wait ? ST_WAIT : ST_RUN;
    endfunction

    task automatic m_bubble();
        m_if_pc    = '0;
        m_if_instr = NOP;
        m_if_valid = 1'b0;
        if (m_nb != {CNT_W{1'b1}}) m_nb = m_nb + 1;
    endtask

    // Advances the model by one edge from the current inputs, then the clock.
    task automatic tick();
        if (rst) begin
            m_pc = RESET_PC; m_boot = 1'b1; m_wait = 1'b0;
            m_if_pc = '0; m_if_instr = NOP; m_if_valid = 1'b0;
            m_nf = '0; m_nb = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (jump_i || branch_taken_i) begin
            m_pc = jump_i ? jump_target_i : branch_target_i;
            m_wait = 1'b0;
            m_bubble();
        end else if (flush_i) begin
            m_bubble();
            if (imem_bus.imem_rvalid_i) m_pc = m_pc + 64'd4;
            m_wait = !imem_bus.imem_rvalid_i;
        end else if (!stall_i) begin
            if (imem_bus.imem_rvalid_i) begin
                m_if_pc = m_pc; m_if_instr = imem_bus.imem_rdata_i; m_if_valid = 1'b1;
                if (m_nf != {CNT_W{1'b1}}) m_nf = m_nf + 1;
                m_pc = m_pc + 64'd4;
                m_wait = 1'b0;
            end else begin
                m_bubble();
                m_wait = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        stall_i = 0; flush_i = 0; branch_taken_i = 0; jump_i = 0;
        branch_target_i = '0; jump_target_i = '0;
        imem_bus.imem_rvalid_i = 0; imem_bus.imem_rdata_i = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fetch_word();
        imem_bus.imem_rvalid_i = 1'b1;
        imem_bus.imem_rdata_i  = word_at(m_pc);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_bus.imem_req_o !== 1'b0 || state_o !== ST_BOOT) begin
            errors++;
            $display("FAIL reset_fsm req=%0b state=%0d exp req=0 state=%0d", imem_bus.imem_req_o, state_o, ST_BOOT);
        end
        checks++;
        if (imem_bus.imem_addr_o !== RESET_PC || if_id_pc_o !== 64'h0 || if_id_instr_o !== NOP || if_id_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs addr=%h pc=%h instr=%h v=%0b exp addr=%h pc=0 instr=%h v=0",
                     imem_bus.imem_addr_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, RESET_PC, NOP);
        end
        checks++;
        if (cnt_fetch_o !== '0 || cnt_bubble_o !== '0) begin
            errors++;
            $display("FAIL reset_cnt fetch=%0d bubble=%0d exp 0 0", cnt_fetch_o, cnt_bubble_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_boot_fetch();
        do_reset();
        imem_bus.imem_rvalid_i = 1'b1;
        imem_bus.imem_rdata_i  = 32'h0050_0093;
        checks++;
        if (imem_bus.imem_req_o !== 1'b0 || state_o !== ST_BOOT) begin
            errors++;
            $display("FAIL boot_noreq req=%0b state=%0d exp req=0 BOOT", imem_bus.imem_req_o, state_o);
        end
        tick();
        checks++;
        if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 64'h0 || state_o !== ST_RUN || if_id_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL boot_to_run req=%0b addr=%h state=%0d v=%0b exp 1 0 RUN 0",
                     imem_bus.imem_req_o, imem_bus.imem_addr_o, state_o, if_id_valid_o);
        end
        tick();
        checks++;
        if (if_id_pc_o !== 64'h0 || if_id_instr_o !== 32'h0050_0093 || if_id_valid_o !== 1'b1 || imem_bus.imem_addr_o !== 64'h4) begin
            errors++;
            $display("FAIL first_fetch pc=%h instr=%h v=%0b addr=%h exp 0 00500093 1 4",
                     if_id_pc_o, if_id_instr_o, if_id_valid_o, imem_bus.imem_addr_o);
        end
    endtask

    task automatic test_stall();
        fetch_word();
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fetch_word();
            checks++;
            if (if_id_pc_o !== 64'h4 || if_id_instr_o !== word_at(64'h4) || imem_bus.imem_addr_o !== 64'h8) begin
                errors++;
                $display("FAIL stall_hold%0d pc=%h instr=%h addr=%h exp 4 %h 8", i, if_id_pc_o, if_id_instr_o, imem_bus.imem_addr_o, word_at(64'h4));
            end
        end
        stall_i = 1'b0;
        fetch_word();
        fetch_word();
        checks++;
        if (if_id_pc_o !== 64'hC || if_id_valid_o !== 1'b1 || imem_bus.imem_addr_o !== 64'h10) begin
            errors++;
            $display("FAIL stall_resume pc=%h v=%0b addr=%h exp c 1 10", if_id_pc_o, if_id_valid_o, imem_bus.imem_addr_o);
        end
    endtask

    task automatic test_branch_stall();
        branch_taken_i = 1'b1; branch_target_i = 64'h40; stall_i = 1'b1;
        fetch_word();
        set_idle();
        checks++;
        if (if_id_instr_o !== NOP || if_id_valid_o !== 1'b0 || imem_bus.imem_addr_o !== 64'h40) begin
            errors++;
            $display("FAIL branch_stall instr=%h v=%0b addr=%h exp 13 0 40", if_id_instr_o, if_id_valid_o, imem_bus.imem_addr_o);
        end
        fetch_word();
        checks++;
        if (if_id_pc_o !== 64'h40 || if_id_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL branch_target_fetch pc=%h v=%0b exp 40 1", if_id_pc_o, if_id_valid_o);
        end
    endtask

    task automatic test_jump_branch();
        jump_i = 1'b1; jump_target_i = 64'h80;
        branch_taken_i = 1'b1; branch_target_i = 64'h40;
        fetch_word();
        set_idle();
        checks++;
        if (imem_bus.imem_addr_o !== 64'h80 || if_id_valid_o !== 1'b0 || state_o !== ST_RUN) begin
            errors++;
            $display("FAIL jump_wins addr=%h v=%0b state=%0d exp 80 0 RUN", imem_bus.imem_addr_o, if_id_valid_o, state_o);
        end
    endtask

    task automatic test_wait();
        do_reset();
        for (int i = 0; i < 5; i++) fetch_word();
        imem_bus.imem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state_o !== ST_WAIT || imem_bus.imem_addr_o !== 64'h10 || imem_bus.imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold%0d state=%0d addr=%h req=%0b v=%0b exp WAIT 10 1 0",
                         i, state_o, imem_bus.imem_addr_o, imem_bus.imem_req_o, if_id_valid_o);
            end
        end
        checks++;
        if (cnt_bubble_o !== (PERF_EN ? 32'd3 : 32'd0) || cnt_fetch_o !== (PERF_EN ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL wait_counters bubble=%0d fetch=%0d exp %0d %0d", cnt_bubble_o, cnt_fetch_o,
                     PERF_EN ? 3 : 0, PERF_EN ? 4 : 0);
        end
        fetch_word();
        checks++;
        if (if_id_pc_o !== 64'h10 || if_id_valid_o !== 1'b1 || state_o !== ST_RUN) begin
            errors++;
            $display("FAIL wait_release pc=%h v=%0b state=%0d exp 10 1 RUN", if_id_pc_o, if_id_valid_o, state_o);
        end
    endtask

    task automatic test_reset_in_wait();
        for (int i = 0; i < 4; i++) fetch_word();
        imem_bus.imem_rvalid_i = 1'b0;
        tick();
        checks++;
        if (state_o !== ST_WAIT || imem_bus.imem_addr_o !== 64'h24) begin
            errors++;
            $display("FAIL pre_reset state=%0d addr=%h exp WAIT 24", state_o, imem_bus.imem_addr_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (imem_bus.imem_addr_o !== 64'h0 || if_id_valid_o !== 1'b0 || state_o !== ST_BOOT ||
            cnt_fetch_o !== '0 || cnt_bubble_o !== '0) begin
            errors++;
            $display("FAIL reset_in_wait addr=%h v=%0b state=%0d cf=%0d cb=%0d exp 0 0 BOOT 0 0",
                     imem_bus.imem_addr_o, if_id_valid_o, state_o, cnt_fetch_o, cnt_bubble_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) fetch_word();
        flush_i = 1'b1;
        fetch_word();
        checks++;
        if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || imem_bus.imem_addr_o !== 64'hC) begin
            errors++;
            $display("FAIL flush_rvalid v=%0b instr=%h addr=%h exp 0 13 c", if_id_valid_o, if_id_instr_o, imem_bus.imem_addr_o);
        end
        imem_bus.imem_rvalid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        checks++;
        if (imem_bus.imem_addr_o !== 64'hC || state_o !== ST_WAIT || if_id_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_norvalid addr=%h state=%0d v=%0b exp c WAIT 0", imem_bus.imem_addr_o, state_o, if_id_valid_o);
        end
    endtask

    task automatic test_pc_wrap();
        branch_taken_i = 1'b1; branch_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        set_idle();
        fetch_word();
        checks++;
        if (if_id_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || imem_bus.imem_addr_o !== 64'h0 || if_id_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap pc=%h addr=%h v=%0b exp fffffffffffffffc 0 1", if_id_pc_o, imem_bus.imem_addr_o, if_id_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({64'(i * 4), word_at(64'(i * 4))});
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 200) begin
            imem_bus.imem_rvalid_i = ($urandom_range(0, 3) != 0);
            imem_bus.imem_rdata_i  = word_at(m_pc);
            tick();
            cycles++;
            if (if_id_valid_o === 1'b1) begin
                logic [95:0] exp_e;
                exp_e = exp_q.pop_front();
                checks++;
                if ({if_id_pc_o, if_id_instr_o} !== exp_e) begin
                    errors++;
                    $display("FAIL b2b_word got=%h exp=%h", {if_id_pc_o, if_id_instr_o}, exp_e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_timeout remaining=%0d exp 0", exp_q.size());
        end
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            stall_i         = ($urandom_range(0, 4) == 0);
            flush_i         = ($urandom_range(0, 7) == 0);
            branch_taken_i  = ($urandom_range(0, 9) == 0);
            jump_i          = ($urandom_range(0, 14) == 0);
            branch_target_i = {$urandom(), $urandom()};
            jump_target_i   = {$urandom(), $urandom()};
            imem_bus.imem_rvalid_i = ($urandom_range(0, 3) != 0);
            imem_bus.imem_rdata_i  = $urandom();
            tick();
            checks++;
            if (state_o !== m_state() || imem_bus.imem_addr_o !== m_pc || imem_bus.imem_req_o !== !m_boot) begin
                errors++;
                $display("FAIL rnd_fetch cyc=%0d state=%0d addr=%h req=%0b exp %0d %h %0b",
                         i, state_o, imem_bus.imem_addr_o, imem_bus.imem_req_o, m_state(), m_pc, !m_boot);
            end
            checks++;
            if (if_id_valid_o !== m_if_valid || if_id_instr_o !== m_if_instr || (m_if_valid && if_id_pc_o !== m_if_pc)) begin
                errors++;
                $display("FAIL rnd_ifid cyc=%0d v=%0b instr=%h pc=%h exp %0b %h %h",
                         i, if_id_valid_o, if_id_instr_o, if_id_pc_o, m_if_valid, m_if_instr, m_if_pc);
            end
            checks++;
            if (cnt_fetch_o !== (PERF_EN ? m_nf : '0) || cnt_bubble_o !== (PERF_EN ? m_nb : '0)) begin
                errors++;
                $display("FAIL rnd_cnt cyc=%0d fetch=%0d bubble=%0d exp %0d %0d",
                         i, cnt_fetch_o, cnt_bubble_o, PERF_EN ? m_nf : 0, PERF_EN ? m_nb : 0);
            end
        end
        rst = 1'b0;
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_boot_fetch();
        test_stall();
        test_branch_stall();
        test_jump_branch();
        test_wait();
        test_reset_in_wait();
        test_flush();
        test_pc_wrap();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
